// File: rtl/wb_arbiter.sv
// Write-back arbiter: two one-entry producer buffers (ALU, LSU) merged round-robin onto one register-file write port.
// Optional pending-write scoreboard built when WB_SCOREBOARD_EN is defined.
module wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int SIZE   = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              rf_en,
   output logic              rf_wr,
   output logic [ADDR_W-1:0] rf_addr_wr,
   output logic [DATA_W-1:0] rf_data_wr,
   input  logic              sb_set,
   input  logic [ADDR_W-1:0] sb_set_addr,
   input  logic [ADDR_W-1:0] sb_q_addr1,
   input  logic [ADDR_W-1:0] sb_q_addr2,
   output logic              sb_busy1,
   output logic              sb_busy2
);

   logic              alu_full_q, alu_full_d, lsu_full_q, lsu_full_d;
   logic [ADDR_W-1:0] alu_addr_q, alu_addr_d, lsu_addr_q, lsu_addr_d;
   logic [DATA_W-1:0] alu_data_q, alu_data_d, lsu_data_q, lsu_data_d;
   logic              last_lsu_q, last_lsu_d;
   logic              rf_en_q, rf_wr_q, rf_wr_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;
   logic              alu_grant, lsu_grant;

   always_comb begin
      // On a conflict the source that did not win last time goes first.
      alu_grant  = alu_full_q && (!lsu_full_q || last_lsu_q);
      lsu_grant  = lsu_full_q && (!alu_full_q || !last_lsu_q);
      alu_ready  = !alu_full_q || alu_grant;
      lsu_ready  = !lsu_full_q || lsu_grant;

      alu_full_d = alu_full_q && !alu_grant;
      alu_addr_d = alu_addr_q;
      alu_data_d = alu_data_q;
      if (alu_valid && alu_ready && alu_addr != '0) begin
         alu_full_d = 1'b1;
         alu_addr_d = alu_addr;
         alu_data_d = alu_data;
      end

      lsu_full_d = lsu_full_q && !lsu_grant;
      lsu_addr_d = lsu_addr_q;
      lsu_data_d = lsu_data_q;
      if (lsu_valid && lsu_ready && lsu_addr != '0) begin
         lsu_full_d = 1'b1;
         lsu_addr_d = lsu_addr;
         lsu_data_d = lsu_data;
      end

      rf_wr_d    = alu_grant || lsu_grant;
      rf_addr_d  = rf_addr_q;
      rf_data_d  = rf_data_q;
      last_lsu_d = last_lsu_q;
      if (alu_grant) begin
         rf_addr_d  = alu_addr_q;
         rf_data_d  = alu_data_q;
         last_lsu_d = 1'b0;
      end else if (lsu_grant) begin
         rf_addr_d  = lsu_addr_q;
         rf_data_d  = lsu_data_q;
         last_lsu_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_full_q <= 1'b0;
         alu_addr_q <= '0;
         alu_data_q <= '0;
         lsu_full_q <= 1'b0;
         lsu_addr_q <= '0;
         lsu_data_q <= '0;
         last_lsu_q <= 1'b0;
         rf_en_q    <= 1'b0;
         rf_wr_q    <= 1'b0;
         rf_addr_q  <= '0;
         rf_data_q  <= '0;
      end else begin
         alu_full_q <= alu_full_d;
         alu_addr_q <= alu_addr_d;
         alu_data_q <= alu_data_d;
         lsu_full_q <= lsu_full_d;
         lsu_addr_q <= lsu_addr_d;
         lsu_data_q <= lsu_data_d;
         last_lsu_q <= last_lsu_d;
         rf_en_q    <= 1'b1;
         rf_wr_q    <= rf_wr_d;
         rf_addr_q  <= rf_addr_d;
         rf_data_q  <= rf_data_d;
      end
   end

   assign rf_en      = rf_en_q;
   assign rf_wr      = rf_wr_q;
   assign rf_addr_wr = rf_addr_q;
   assign rf_data_wr = rf_data_q;

`ifdef WB_SCOREBOARD_EN
   logic [SIZE-1:0] busy_q, busy_d;

   // Set is applied after clear so a same-edge set on the retiring address wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_wr_q) busy_d[rf_addr_q] = 1'b0;
      if (sb_set && sb_set_addr != '0) busy_d[sb_set_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign sb_busy1 = busy_q[sb_q_addr1] && !(rf_wr_q && rf_addr_q == sb_q_addr1);
   assign sb_busy2 = busy_q[sb_q_addr2] && !(rf_wr_q && rf_addr_q == sb_q_addr2);
`else
   logic unused_sb;
   assign unused_sb = ^{sb_set, sb_set_addr, sb_q_addr1, sb_q_addr2};
   assign sb_busy1  = 1'b0;
   assign sb_busy2  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-cycle comparison against a source-level model plus directed scenarios with literal expectations.
module tb_wb_arbiter;
`ifdef WB_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0, lsu_valid = 1'b0;
   logic        alu_ready, lsu_ready;
   logic [4:0]  alu_addr = '0, lsu_addr = '0;
   logic [31:0] alu_data = '0, lsu_data = '0;
   logic        rf_en, rf_wr;
   logic [4:0]  rf_addr_wr;
   logic [31:0] rf_data_wr;
   logic        sb_set = 1'b0;
   logic [4:0]  sb_set_addr = '0, sb_q_addr1 = '0, sb_q_addr2 = '0;
   logic        sb_busy1, sb_busy2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
      .rf_en(rf_en), .rf_wr(rf_wr), .rf_addr_wr(rf_addr_wr), .rf_data_wr(rf_data_wr),
      .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_q_addr1(sb_q_addr1), .sb_q_addr2(sb_q_addr2),
      .sb_busy1(sb_busy1), .sb_busy2(sb_busy2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model (index 0 = ALU, 1 = LSU) ----------------
   bit          m_full[2];
   logic [4:0]  m_addr[2];
   logic [31:0] m_data[2];
   int          m_last;
   bit          m_en, m_wr;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   bit [31:0]   m_busy;

   function automatic int winner();
      if (m_full[0] && m_full[1]) return (m_last == 0) ? 1 : 0;
      if (m_full[0]) return 0;
      if (m_full[1]) return 1;
      return -1;
   endfunction

   function automatic bit in_v(int s);
      return (s == 0) ? alu_valid : lsu_valid;
   endfunction
   function automatic logic [4:0] in_a(int s);
      return (s == 0) ? alu_addr : lsu_addr;
   endfunction
   function automatic logic [31:0] in_d(int s);
      return (s == 0) ? alu_data : lsu_data;
   endfunction
   function automatic bit m_ready(int s);
      return !m_full[s] || (winner() == s);
   endfunction
   function automatic bit m_busy_q(logic [4:0] q);
      return SB && m_busy[q] && !(m_wr && m_waddr == q);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            m_full[s] <= 1'b0;
            m_addr[s] <= '0;
            m_data[s] <= '0;
         end
         m_last  <= 0;
         m_en    <= 1'b0;
         m_wr    <= 1'b0;
         m_waddr <= '0;
         m_wdata <= '0;
         m_busy  <= '0;
      end else begin
         m_en <= 1'b1;
         if (winner() >= 0) begin
            m_wr    <= 1'b1;
            m_waddr <= m_addr[winner()];
            m_wdata <= m_data[winner()];
            m_last  <= winner();
         end else begin
            m_wr <= 1'b0;
         end
         for (int s = 0; s < 2; s++) begin
            if (in_v(s) && m_ready(s) && in_a(s) != 0) begin
               m_full[s] <= 1'b1;
               m_addr[s] <= in_a(s);
               m_data[s] <= in_d(s);
            end else if (winner() == s) begin
               m_full[s] <= 1'b0;
            end
         end
         if (SB) begin
            if (m_wr) m_busy[m_waddr] <= 1'b0;
            if (sb_set && sb_set_addr != 0) m_busy[sb_set_addr] <= 1'b1;
         end
      end
   end

   // ---------------- write log and per-cycle compare ----------------
   typedef struct { int c; logic [4:0] a; logic [31:0] d; } wr_t;
   wr_t wlog[$];

   always @(negedge clk) begin
      if (rst) begin
         check("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
         check("rst_lsu_ready", {31'b0, lsu_ready}, 32'd1);
         check("rst_rf_en", {31'b0, rf_en}, 32'd0);
         check("rst_rf_wr", {31'b0, rf_wr}, 32'd0);
         check("rst_rf_addr", {27'b0, rf_addr_wr}, 32'd0);
         check("rst_rf_data", rf_data_wr, 32'd0);
         check("rst_sb_busy1", {31'b0, sb_busy1}, 32'd0);
      end else begin
         check("alu_ready", {31'b0, alu_ready}, {31'b0, m_ready(0)});
         check("lsu_ready", {31'b0, lsu_ready}, {31'b0, m_ready(1)});
         check("rf_en", {31'b0, rf_en}, {31'b0, m_en});
         check("rf_wr", {31'b0, rf_wr}, {31'b0, m_wr});
         check("rf_addr_wr", {27'b0, rf_addr_wr}, {27'b0, m_waddr});
         check("rf_data_wr", rf_data_wr, m_wdata);
         check("sb_busy1", {31'b0, sb_busy1}, {31'b0, m_busy_q(sb_q_addr1)});
         check("sb_busy2", {31'b0, sb_busy2}, {31'b0, m_busy_q(sb_q_addr2)});
         if (rf_wr) wlog.push_back('{cyc, rf_addr_wr, rf_data_wr});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- directed scenarios ----------------
   int base;
   bit ha, hl;
   logic [4:0]  exp_a[8] = '{5'd6, 5'd5, 5'd6, 5'd5, 5'd6, 5'd5, 5'd6, 5'd5};
   logic [31:0] exp_d[8] = '{32'h22, 32'h11, 32'h23, 32'h12, 32'h24, 32'h13, 32'h25, 32'h14};

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // single ALU write
      alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 1'b0;
      @(negedge clk);
      check("single_wr_early", {31'b0, rf_wr}, 32'd0);
      tick();
      @(negedge clk);
      check("single_wr", {31'b0, rf_wr}, 32'd1);
      check("single_addr", {27'b0, rf_addr_wr}, 32'd3);
      check("single_data", rf_data_wr, 32'hDEADBEEF);
      check("single_en", {31'b0, rf_en}, 32'd1);
      tick();
      @(negedge clk);
      check("single_wr_drop", {31'b0, rf_wr}, 32'd0);
      repeat (2) tick();

      // conflict and round-robin
      base = wlog.size();
      alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11;
      lsu_valid = 1'b1; lsu_addr = 5'd6; lsu_data = 32'h22;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         ha = alu_ready;
         hl = lsu_ready;
         if (k > 0) begin
            check("rr_alu_ready", {31'b0, ha}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_lsu_ready", {31'b0, hl}, (k % 2 == 0) ? 32'd0 : 32'd1);
         end
         tick();
         if (ha) alu_data = alu_data + 1;
         if (hl) lsu_data = lsu_data + 1;
      end
      alu_valid = 1'b0; lsu_valid = 1'b0;
      repeat (4) tick();
      check("rr_count", wlog.size() - base, 32'd8);
      if (wlog.size() >= base + 8)
         for (int i = 0; i < 8; i++) begin
            check("rr_addr", {27'b0, wlog[base+i].a}, {27'b0, exp_a[i]});
            check("rr_data", wlog[base+i].d, exp_d[i]);
         end

      // r0 discard
      base = wlog.size();
      lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h55;
      @(negedge clk);
      check("r0_ready", {31'b0, lsu_ready}, 32'd1);
      tick();
      lsu_valid = 1'b0;
      @(negedge clk);
      check("r0_empty_ready", {31'b0, lsu_ready}, 32'd1);
      check("r0_no_wr", {31'b0, rf_wr}, 32'd0);
      repeat (2) tick();
      check("r0_no_log", wlog.size() - base, 32'd0);

      // back-to-back throughput
      base = wlog.size();
      for (int i = 1; i <= 8; i++) begin
         alu_valid = 1'b1; alu_addr = 5'(i); alu_data = 32'h100 + i;
         @(negedge clk);
         check("b2b_ready", {31'b0, alu_ready}, 32'd1);
         tick();
      end
      alu_valid = 1'b0;
      repeat (3) tick();
      check("b2b_count", wlog.size() - base, 32'd8);
      if (wlog.size() >= base + 8)
         for (int i = 0; i < 8; i++) begin
            check("b2b_addr", {27'b0, wlog[base+i].a}, i + 1);
            check("b2b_data", wlog[base+i].d, 32'h101 + i);
            check("b2b_consec", wlog[base+i].c - wlog[base].c, i);
         end

      // reset mid-flight
      alu_valid = 1'b1; alu_addr = 5'd9;  alu_data = 32'h99;
      lsu_valid = 1'b1; lsu_addr = 5'd10; lsu_data = 32'hAA;
      tick();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      @(posedge clk);
      #1;
      check("mid_wr_before", {31'b0, rf_wr}, 32'd1);
      check("mid_addr_before", {27'b0, rf_addr_wr}, 32'd10);
      #1 rst = 1'b1;
      #1;
      check("mid_wr_async", {31'b0, rf_wr}, 32'd0);
      check("mid_alu_ready", {31'b0, alu_ready}, 32'd1);
      check("mid_lsu_ready", {31'b0, lsu_ready}, 32'd1);
      base = wlog.size();
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      check("mid_no_wr_after", wlog.size() - base, 32'd0);

      // scoreboard
      sb_set = 1'b1; sb_set_addr = 5'd7; sb_q_addr1 = 5'd7; sb_q_addr2 = 5'd5;
      tick();
      sb_set = 1'b0;
      @(negedge clk);
      check("sb_set_busy", {31'b0, sb_busy1}, {31'b0, SB});
      check("sb_other_idle", {31'b0, sb_busy2}, 32'd0);
      tick();
      alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
      tick();
      alu_valid = 1'b0;
      @(negedge clk);
      check("sb_pending", {31'b0, sb_busy1}, {31'b0, SB});
      tick();
      sb_set = 1'b1; sb_set_addr = 5'd7;
      @(negedge clk);
      check("sb_fwd_wr", {31'b0, rf_wr}, 32'd1);
      check("sb_fwd_clear", {31'b0, sb_busy1}, 32'd0);
      tick();
      sb_set = 1'b0;
      @(negedge clk);
      check("sb_set_wins", {31'b0, sb_busy1}, {31'b0, SB});
      alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h78;
      tick();
      alu_valid = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      check("sb_cleared", {31'b0, sb_busy1}, 32'd0);
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the core's register file. Merges results from two producers, the ALU and the load/store unit, onto the register file's single write port. Each producer has a one-entry buffer. The block grants producers round-robin and drives a registered write stage. An optional scoreboard tracks destination registers with writes in flight, for the issue stage.

## Interface
- `DATA_W`, default 32: data width; must match the register file.
- `ADDR_W`, default 5: register address width.
- `SIZE`, default 2**ADDR_W: number of architectural registers.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_addr`  in  ADDR_W  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `lsu_valid`, `lsu_ready`, `lsu_addr`, `lsu_data`: same directions, widths and meanings, for the LSU.
- `rf_en`  out  1  register file enable.
- `rf_wr`  out  1  register file write strobe.
- `rf_addr_wr`  out  ADDR_W  write address.
- `rf_data_wr`  out  DATA_W  write data.
- `sb_set`  in  1  issue stage marks a destination as pending.
- `sb_set_addr`  in  ADDR_W  destination being marked.
- `sb_q_addr1`, `sb_q_addr2`  in  ADDR_W  scoreboard query addresses.
- `sb_busy1`, `sb_busy2`  out  1  query result: register has a write pending.

## Operation
- **Input buffers.** Each source has one buffer: a full flag plus address and data.
  - `x_ready = !x_full || x_grant` (combinational).
  - On `x_valid && x_ready`, the buffer loads.
  - Exception: if `x_addr == 0`, the transfer is acknowledged but nothing is stored; `x_full` is not set by it.
- **Arbitration.** Combinational, among full buffers.
  - One buffer full: it is granted.
  - Both full: the source not granted last wins.
  - The last-grant pointer updates only on a grant. Reset value = ALU, so the LSU wins the first conflict.
- **Grant.** The granted buffer empties at the edge, unless it reloads in the same cycle.
  - At that same edge, `rf_wr <= 1`, `rf_addr_wr <= buf_addr`, `rf_data_wr <= buf_data`.
  - With no grant, `rf_wr <= 0`. Address and data hold their previous values.
- **Enable.** `rf_en` is registered: 0 in reset, 1 from the first edge after reset is released.
- **Simultaneous accept and grant** on the same source: the new entry replaces the old one. Full throughput is 1 write per cycle in total.

## Timing
- **Reset values.** `rf_en=0`, `rf_wr=0`, `rf_addr_wr=0`, `rf_data_wr=0`, both buffers empty, pointer=ALU, scoreboard all 0, `sb_busy*=0`.
  - `x_ready=1` while `rst` is asserted. Handshakes during reset are ignored.
- **Latency.**
  - Handshake at edge E0 → buffer full.
  - Uncontended, grant in the cycle after E0 → `rf_wr` high after E1.
  - Register file write lands at E2.
  - Loser of a conflict: one extra cycle per waiting grant.
- **Reset mid-operation.** Buffered or in-flight results are discarded immediately; `rf_wr` drops asynchronously.
- **Back-pressure.** A source may hold `valid` with stable `addr`/`data` indefinitely. `ready` never depends on `valid` of the same source.

## Configuration
- `WB_SCOREBOARD_EN` defined:
  - `busy[SIZE-1:1]` register vector; bit 0 is always 0.
  - Edge with `sb_set && sb_set_addr != 0` → bit set.
  - Edge with `rf_wr` → bit `rf_addr_wr` cleared.
  - Same address set and cleared at one edge → set wins.
  - `sb_busy1 = busy[sb_q_addr1] && !(rf_wr && rf_addr_wr == sb_q_addr1)`. This matches the register file's same-cycle write forwarding. `sb_busy2` is the same, using `sb_q_addr2`.
- `WB_SCOREBOARD_EN` undefined:
  - No scoreboard storage.
  - `sb_busy1 = sb_busy2 = 0`.
  - `sb_set` and `sb_set_addr` are ignored.
  - Arbitration path is unchanged.

## Test plan
- **Single ALU write.** Release reset, then `alu_valid=1`, `alu_addr=3`, `alu_data=0xDEADBEEF` for 1 cycle → after 2 edges `rf_wr=1`, `rf_addr_wr=3`, `rf_data_wr=0xDEADBEEF` for exactly 1 cycle; `rf_en=1`.
- **Conflict and round-robin.** Both sources valid, ALU→r5=0x11 and LSU→r6=0x22, same cycle, then held with new data each accept → writes alternate LSU, ALU, LSU, …; neither source starves; `lsu_ready` and `alu_ready` pulse on alternate cycles.
- **r0 discard.** `lsu_valid=1`, `lsu_addr=0`, `lsu_data=0x55` → `lsu_ready=1`, buffer stays empty, `rf_wr` stays 0.
- **Back-to-back throughput.** ALU valid for 8 consecutive cycles, addresses 1..8 → 8 consecutive `rf_wr` pulses with matching addresses; `alu_ready` stays high throughout.
- **Reset mid-flight.** Buffer both sources, assert `rst` in the grant cycle → `rf_wr=0` immediately, no writes after release, both `ready=1`.
- **Scoreboard** (`WB_SCOREBOARD_EN`):
  - `sb_set` r7, then query r7 → `sb_busy1=1`.
  - Cycle where `rf_wr` targets r7 → `sb_busy1=0`.
  - `sb_set` r7 in that same cycle → `busy[7]` remains 1 in the next cycle.
